// File: rtl/hash_io_if.sv
// hash_io_if
// Host-side I/O wrapper for a hash core. The host writes the 32-bit message
// block as two IOW-bit half-words and reads the digest back one word at a time,
// most significant word first. Every host transfer is acknowledged with a
// single-cycle ack, so a request that stays high transfers at most once every
// two cycles.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   init         host: start a new message (has priority over load/fetch)
//   load         host: write idata into the message block
//   fetch        host: read one digest word into odata
//   idata        host write data (IOW bits)
//   ack          one-cycle transfer acknowledge
//   odata        host read data, registered; holds between fetches
//   err          sticky protocol-error flag, cleared by init or reset
//   core_init    one-cycle pulse: core clears its chaining state
//   core_start   one-cycle pulse: core_msg is valid
//   core_msg     32-bit message block to the core
//   core_done    one-cycle pulse from the core: block finished
//   core_digest  current digest (DGW bits), stable while the core is idle
module hash_io_if #(
    parameter int IOW = 16,
    parameter int DGW = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init,
    input  logic           load,
    input  logic           fetch,
    input  logic [IOW-1:0] idata,
    output logic           ack,
    output logic [IOW-1:0] odata,
    output logic           err,
    output logic           core_init,
    output logic           core_start,
    output logic [31:0]    core_msg,
    input  logic           core_done,
    input  logic [DGW-1:0] core_digest
);

    localparam int NW  = DGW / IOW;
    localparam int FPW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_BUSY
    } state_t;

    state_t         state_reg;
    logic           hw_reg;
    logic [FPW-1:0] fp_reg;

    // Digest split into host-sized words; word 0 is the most significant.
    logic [IOW-1:0] dig_word [NW];

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_dig_word
            assign dig_word[gi] = core_digest[DGW-1-IOW*gi -: IOW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_EMPTY;
            hw_reg     <= 1'b0;
            fp_reg     <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
            core_init  <= 1'b0;
            core_start <= 1'b0;
            odata      <= '0;
            core_msg   <= '0;
        end else begin
            // Pulses last exactly one cycle.
            ack        <= 1'b0;
            core_init  <= 1'b0;
            core_start <= 1'b0;

            if (init && !ack) begin
                // Accepted in any state; abandons any block in flight.
                // core_start is not raised on this path, so it can never
                // coincide with core_init.
                core_init <= 1'b1;
                ack       <= 1'b1;
                hw_reg    <= 1'b0;
                fp_reg    <= '0;
                err       <= 1'b0;
                state_reg <= S_LOAD;
            end else begin
                // core_done is only meaningful while a block is running.
                // Host requests held during S_BUSY are served on the edge
                // after the return to S_LOAD, not on the core_done edge.
                if (state_reg == S_BUSY && core_done) begin
                    state_reg <= S_LOAD;
                end

                if (!ack && state_reg != S_BUSY) begin
                    if (load && fetch) begin
                        err <= 1'b1;
                    end else if (state_reg == S_EMPTY) begin
                        if (load || fetch) begin
                            err <= 1'b1;
                        end
                    end else if (load) begin
                        ack <= 1'b1;
                        if (!hw_reg) begin
                            core_msg[31:16] <= 16'(idata);
                            hw_reg          <= 1'b1;
                        end else begin
                            core_msg[15:0] <= 16'(idata);
                            hw_reg         <= 1'b0;
                            core_start     <= 1'b1;
                            state_reg      <= S_BUSY;
                        end
                    end else if (fetch) begin
                        // Reading the digest mid-block (half a message
                        // written) is a protocol error.
                        if (hw_reg) begin
                            err <= 1'b1;
                        end else begin
                            odata  <= dig_word[fp_reg];
                            fp_reg <= (fp_reg == FPW'(NW - 1)) ? '0 : fp_reg + 1'b1;
                            ack    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hash_io_if.sv
module tb_hash_io_if;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init, load, fetch;
    logic [15:0]  idata;
    logic         ack;
    logic [15:0]  odata;
    logic         err;
    logic         core_init, core_start;
    logic [31:0]  core_msg;
    logic         core_done;
    logic [255:0] core_digest;

    int checks   = 0;
    int failures = 0;
    int ack_count   = 0;
    int start_count = 0;

    typedef struct packed {
        logic        is_init;
        logic        is_start;
        logic        has_od;
        logic [15:0] od;
        logic        has_msg;
        logic [31:0] msg;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hash_io_if #(.IOW(16), .DGW(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (init),
        .load        (load),
        .fetch       (fetch),
        .idata       (idata),
        .ack         (ack),
        .odata       (odata),
        .err         (err),
        .core_init   (core_init),
        .core_start  (core_start),
        .core_msg    (core_msg),
        .core_done   (core_done),
        .core_digest (core_digest)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every ack pops one expected response from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) start_count++;
            if (core_init || core_start)
                chk("init_start_exclusive", 64'(core_init & core_start), 64'd0);
            if (ack) begin
                exp_t e;
                ack_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_core_init", 64'(core_init), 64'(e.is_init));
                    chk("ack_core_start", 64'(core_start), 64'(e.is_start));
                    if (e.has_od)  chk("ack_odata", 64'(odata), 64'(e.od));
                    if (e.has_msg) chk("ack_core_msg", 64'(core_msg), 64'(e.msg));
                end
            end
        end
    end

    // Each op starts 1 time unit after a rising edge and takes two cycles.
    task automatic op_init();
        exp_q.push_back('{is_init:1'b1, is_start:1'b0, has_od:1'b0, od:16'h0, has_msg:1'b0, msg:32'h0});
        init = 1'b1;
        @(posedge clk); #1 init = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic op_load(input logic [15:0] d, input logic [31:0] emsg, input logic estart);
        exp_q.push_back('{is_init:1'b0, is_start:estart, has_od:1'b0, od:16'h0, has_msg:1'b1, msg:emsg});
        idata = d;
        load  = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic op_fetch(input logic [15:0] eod);
        exp_q.push_back('{is_init:1'b0, is_start:1'b0, has_od:1'b1, od:eod, has_msg:1'b0, msg:32'h0});
        fetch = 1'b1;
        @(posedge clk); #1 fetch = 1'b0;
        @(posedge clk); #1;
    endtask

    // A request that must be refused: no ack and err set.
    task automatic op_bad(input string name, input logic l, input logic f);
        int a0;
        a0 = ack_count;
        load  = l;
        fetch = f;
        @(posedge clk); #1 load = 1'b0; fetch = 1'b0;
        @(posedge clk); #1;
        chk({name, "_no_ack"}, 64'(ack_count - a0), 64'd0);
        chk({name, "_err"}, 64'(err), 64'd1);
    endtask

    initial begin
        int a0;
        int s0;
        rst_n = 1'b0; init = 1'b0; load = 1'b0; fetch = 1'b0;
        idata = 16'h0; core_done = 1'b0; core_digest = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_core_init", 64'(core_init), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_odata", 64'(odata), 64'd0);
        chk("rst_core_msg", 64'(core_msg), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Load before init is a protocol error; init clears it.
        op_bad("load_empty", 1'b1, 1'b0);
        op_init();
        chk("init_clears_err", 64'(err), 64'd0);

        // Two half-word loads launch one block.
        s0 = start_count;
        op_load(16'h1234, 32'h1234_0000, 1'b0);
        op_load(16'hABCD, 32'h1234_ABCD, 1'b1);
        chk("start_once", 64'(start_count - s0), 64'd1);

        // Load while busy stalls until core_done, then acks on the next edge.
        a0 = ack_count;
        idata = 16'h5555;
        load  = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_stall_no_ack", 64'(ack_count - a0), 64'd0);
        chk("busy_no_err", 64'(err), 64'd0);
        exp_q.push_back('{is_init:1'b0, is_start:1'b0, has_od:1'b0, od:16'h0, has_msg:1'b1, msg:32'h5555_ABCD});
        core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        chk("no_ack_on_done_edge", 64'(ack), 64'd0);
        @(posedge clk); #1 load = 1'b0;
        chk("ack_after_done", 64'(ack), 64'd1);
        @(posedge clk); #1;

        // Half a message written: fetch is an error.
        op_bad("fetch_hw1", 1'b0, 1'b1);
        op_init();
        chk("init_clears_err2", 64'(err), 64'd0);

        // Digest words 1..16, MS word first; 17th fetch wraps.
        for (int k = 0; k < 16; k++) core_digest[255-16*k -: 16] = 16'(k + 1);
        for (int i = 0; i < 17; i++) op_fetch(16'((i % 16) + 1));

        // Simultaneous load and fetch: refused, message untouched.
        op_bad("load_and_fetch", 1'b1, 1'b1);
        chk("msg_unchanged", 64'(core_msg), 64'h5555_ABCD);

        // Init after one half-word discards it; no block is started.
        op_init();
        s0 = start_count;
        op_load(16'hAAAA, 32'hAAAA_ABCD, 1'b0);
        op_init();
        chk("no_start_after_abort", 64'(start_count - s0), 64'd0);
        op_load(16'h0000, 32'h0000_ABCD, 1'b0);
        op_load(16'h0001, 32'h0000_0001, 1'b1);
        chk("start_after_restart", 64'(start_count - s0), 64'd1);

        // Asynchronous reset while busy, between clock edges.
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_odata", 64'(odata), 64'd0);
        chk("async_rst_core_msg", 64'(core_msg), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        op_bad("load_after_rst_done", 1'b1, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
